// File: rtl/fp32_pkg.sv
// fp32_pkg: shared FP32 field constants, accumulator state encoding and
// small pack/unpack helpers for the neuron FP32 datapath.
package fp32_pkg;

    localparam int          SIGN_BIT    = 31;
    localparam int          EXP_W       = 8;
    localparam int          MAN_W       = 23;
    localparam int          EXP_BIAS    = 127;
    localparam logic [7:0]  EXP_MAX     = 8'hFF;
    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_DONE  = 3'd4
    } acc_state_e;

    // Unpacked operand: mantissa carries the hidden bit in position MAN_W.
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   mant;
    } fp_unpacked_t;

    // Split an FP32 word; exponent 0 (zero or subnormal) is flushed to a zero magnitude.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] v);
        fp_unpacked_t u;
        u.sign = v[SIGN_BIT];
        u.exp  = v[30:23];
        if (v[30:23] == 8'h00) begin
            u.mant = 24'd0;
        end else begin
            u.mant = {1'b1, v[22:0]};
        end
        return u;
    endfunction

    function automatic logic [31:0] fp_pack(input logic sign, input logic [7:0] exp,
                                            input logic [22:0] man);
        return {sign, exp, man};
    endfunction

    function automatic logic [31:0] fp_make_inf(input logic sign);
        return {sign, EXP_MAX, 23'd0};
    endfunction

endpackage

// File: rtl/fp32_lzc.sv
// fp32_lzc: combinational 25-bit leading-zero counter (25 when the input is zero).
module fp32_lzc (
    input  logic [24:0] vec_s,
    output logic [4:0]  lz_s
);

    // Priority scan from LSB upward so the highest set bit is the final assignment.
    always_comb begin
        lz_s = 5'd25;
        for (int i = 0; i < 25; i++) begin
            if (vec_s[i]) begin
                lz_s = 5'(24 - i);
            end else begin
                lz_s = lz_s;
            end
        end
    end

endmodule

// File: rtl/fp32_mac_accumulator.sv
// fp32_mac_accumulator: sequential FP32 sum of multiplier products, one term per
// WAIT/ALIGN/ADD/NORM pass; result held in DONE until accepted downstream.
// Optional macro FP_ACC_BIAS_EN adds a bias port that seeds each new sum.
module fp32_mac_accumulator
    import fp32_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             exception,
    output logic             overflow,
    output logic             underflow
`ifdef FP_ACC_BIAS_EN
    ,
    input  logic [31:0]      bias
`endif
);

    acc_state_e       state_r, state_next_s;
    logic [31:0]      acc_r, term_r, out_sum_r;
    logic             last_r, in_ready_r, out_valid_r;
    logic [CNT_W-1:0] count_r;
    logic             exc_r, ovf_r, unf_r;
    logic [23:0]      big_m_r, small_m_r;
    logic [7:0]       exp_r;
    logic             sign_r, same_sign_r;
    logic [24:0]      sum_r;

    logic             accept_s, handshake_s;
    fp_unpacked_t     acc_u_s, term_u_s, big_u_s, small_u_s;
    logic [7:0]       diff_s;
    logic [23:0]      small_shift_s;
    logic [24:0]      sum_s;
    logic [4:0]       lz_s, shift_s;
    logic [24:0]      norm_shift_s;
    logic signed [9:0] exp_w_s;
    logic [22:0]      man_s;
    logic [31:0]      norm_res_s;
    logic             norm_ovf_s, norm_unf_s;
    logic [3:0]       unused_norm_s;

    assign accept_s    = in_valid & in_ready_r;
    assign handshake_s = out_valid_r & out_ready;

    fp32_lzc u_lzc (
        .vec_s (sum_r),
        .lz_s  (lz_s)
    );

    // Next-state selection for the align/add/normalise sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_WAIT:  begin
                if (accept_s) begin
                    state_next_s = ST_ALIGN;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_ALIGN: state_next_s = ST_ADD;
            ST_ADD:   state_next_s = ST_NORM;
            ST_NORM:  begin
                if (last_r) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DONE:  begin
                if (handshake_s) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default:  state_next_s = ST_WAIT;
        endcase
    end

    // Alignment: pick the larger-magnitude operand and right-shift the other (truncating).
    always_comb begin
        acc_u_s  = fp_unpack(acc_r);
        term_u_s = fp_unpack(term_r);
        if ({acc_u_s.exp, acc_u_s.mant} >= {term_u_s.exp, term_u_s.mant}) begin
            big_u_s   = acc_u_s;
            small_u_s = term_u_s;
        end else begin
            big_u_s   = term_u_s;
            small_u_s = acc_u_s;
        end
        diff_s = big_u_s.exp - small_u_s.exp;
        if (diff_s >= 8'd25) begin
            small_shift_s = 24'd0;
        end else begin
            small_shift_s = small_u_s.mant >> diff_s;
        end
    end

    // Magnitude add or subtract; the larger operand always sits in big_m_r.
    always_comb begin
        if (same_sign_r) begin
            sum_s = {1'b0, big_m_r} + {1'b0, small_m_r};
        end else begin
            sum_s = {1'b0, big_m_r} - {1'b0, small_m_r};
        end
    end

    // Normalisation with range clamping to +-inf or signed zero.
    always_comb begin
        norm_res_s   = FP_POS_ZERO;
        norm_ovf_s   = 1'b0;
        norm_unf_s   = 1'b0;
        shift_s      = 5'd0;
        norm_shift_s = 25'd0;
        exp_w_s      = 10'sd0;
        man_s        = 23'd0;
        if (sum_r == 25'd0) begin
            norm_res_s = FP_POS_ZERO;
        end else begin
            if (sum_r[24]) begin
                exp_w_s = $signed({2'b00, exp_r}) + 10'sd1;
                man_s   = sum_r[23:1];
            end else begin
                // Bit 24 is clear here, so lz >= 1; shift MSB into the hidden-bit slot 23.
                shift_s      = lz_s - 5'd1;
                norm_shift_s = sum_r << shift_s;
                man_s        = norm_shift_s[22:0];
                exp_w_s      = $signed({2'b00, exp_r}) - $signed({5'd0, shift_s});
            end
            if (exp_w_s > 10'sd254) begin
                norm_res_s = fp_make_inf(sign_r);
                norm_ovf_s = 1'b1;
            end else if (exp_w_s < 10'sd1) begin
                norm_res_s = {sign_r, 31'd0};
                norm_unf_s = 1'b1;
            end else begin
                norm_res_s = fp_pack(sign_r, exp_w_s[7:0], man_s);
            end
        end
    end

    assign unused_norm_s = {norm_shift_s[24:23], exp_w_s[9:8]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_WAIT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath, term counter, sticky flags and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r       <= FP_POS_ZERO;
            term_r      <= 32'd0;
            last_r      <= 1'b0;
            count_r     <= {CNT_W{1'b0}};
            exc_r       <= 1'b0;
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
            big_m_r     <= 24'd0;
            small_m_r   <= 24'd0;
            exp_r       <= 8'd0;
            sign_r      <= 1'b0;
            same_sign_r <= 1'b0;
            sum_r       <= 25'd0;
            out_sum_r   <= 32'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_next_s == ST_WAIT);
            out_valid_r <= (state_next_s == ST_DONE);
            case (state_r)
                ST_WAIT: begin
                    if (accept_s) begin
                        term_r <= in_data;
                        last_r <= in_last;
                        if (count_r != {CNT_W{1'b1}}) begin
                            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
`ifdef FP_ACC_BIAS_EN
                        // A zero count marks the first term of a new sum.
                        if (count_r == {CNT_W{1'b0}}) begin
                            acc_r <= bias;
                            exc_r <= exc_r | (bias[30:23] == EXP_MAX);
                        end
`endif
                    end
                end
                ST_ALIGN: begin
                    exc_r       <= exc_r | (term_r[30:23] == EXP_MAX);
                    big_m_r     <= big_u_s.mant;
                    small_m_r   <= small_shift_s;
                    exp_r       <= big_u_s.exp;
                    sign_r      <= big_u_s.sign;
                    same_sign_r <= (big_u_s.sign == small_u_s.sign);
                end
                ST_ADD: begin
                    sum_r <= sum_s;
                end
                ST_NORM: begin
                    acc_r <= norm_res_s;
                    ovf_r <= ovf_r | norm_ovf_s;
                    unf_r <= unf_r | norm_unf_s;
                    if (last_r) begin
                        out_sum_r <= exc_r ? 32'd0 : norm_res_s;
                    end
                end
                ST_DONE: begin
                    if (handshake_s) begin
                        acc_r     <= FP_POS_ZERO;
                        count_r   <= {CNT_W{1'b0}};
                        exc_r     <= 1'b0;
                        ovf_r     <= 1'b0;
                        unf_r     <= 1'b0;
                        out_sum_r <= 32'd0;
                    end
                end
                default: begin
                    acc_r <= FP_POS_ZERO;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
    assign out_count = count_r;
    assign exception = exc_r;
    assign overflow  = ovf_r;
    assign underflow = unf_r;

endmodule

// File: tb/tb_fp32_mac_accumulator.sv
// tb_fp32_mac_accumulator: table-driven directed vectors plus hand sequences for
// result hold, reset mid-operation and (with FP_ACC_BIAS_EN) the bias seed.
module tb_fp32_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_last, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_sum;
    logic [15:0] out_count;
    logic        exception, overflow, underflow;
    logic [31:0] bias;

    int checks = 0;
    int errors = 0;

    fp32_mac_accumulator #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .exception (exception),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef FP_ACC_BIAS_EN
        ,
        .bias      (bias)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int              n;
        logic [3:0][31:0] t;
        logic [31:0]     sum;
        int              cnt;
        logic            exc;
        logic            ovf;
        logic            chk_ovf;
        logic            unf;
    } vec_t;

    vec_t vecs [9];

    function automatic vec_t mkv(input int n, input logic [31:0] t0, input logic [31:0] t1,
                                 input logic [31:0] t2, input logic [31:0] sum,
                                 input logic exc, input logic ovf, input logic chk_ovf,
                                 input logic unf);
        vec_t v;
        v.n = n; v.t[0] = t0; v.t[1] = t1; v.t[2] = t2; v.t[3] = 32'd0;
        v.sum = sum; v.cnt = n; v.exc = exc; v.ovf = ovf; v.chk_ovf = chk_ovf; v.unf = unf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic send_term(input string tag, input logic [31:0] d, input logic last);
        int waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk({tag, "_in_ready_before_send"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_data = d; in_last = last;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        chk({tag, "_in_ready_after_accept"}, {31'd0, in_ready}, 32'd0);
    endtask

    // Called #1 after the edge that accepted the last term.
    task automatic wait_result(input string tag);
        int lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            chk({tag, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd3);
    endtask

    task automatic check_result(input string tag, input vec_t v);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_out_sum"}, out_sum, v.sum);
        chk({tag, "_out_count"}, {16'd0, out_count}, 32'(v.cnt));
        chk({tag, "_exception"}, {31'd0, exception}, {31'd0, v.exc});
        chk({tag, "_underflow"}, {31'd0, underflow}, {31'd0, v.unf});
        if (v.chk_ovf) begin
            chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, v.ovf});
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_hs_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_hs_count_clear"}, {16'd0, out_count}, 32'd0);
        chk({tag, "_hs_flags_clear"}, {29'd0, exception, overflow, underflow}, 32'd0);
        chk({tag, "_hs_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        for (int k = 0; k < v.n; k++) begin
            send_term(tag, v.t[k], (k == v.n - 1));
        end
        wait_result(tag);
        check_result(tag, v);
        handshake(tag);
    endtask

    initial begin
        vec_t hv;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 32'd0;
        out_ready = 1'b0; bias = 32'd0;

        vecs[0] = mkv(3, 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40600000, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[1] = mkv(2, 32'h3FC00000, 32'hBFC00000, 32'd0,        32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[2] = mkv(2, 32'h7F000000, 32'h7F000000, 32'd0,        32'h7F800000, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[3] = mkv(2, 32'h7F800000, 32'h3F800000, 32'd0,        32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[4] = mkv(1, 32'h40000000, 32'd0,        32'd0,        32'h40000000, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[5] = mkv(1, 32'h00400000, 32'd0,        32'd0,        32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[6] = mkv(2, 32'hBF800000, 32'hC0000000, 32'd0,        32'hC0400000, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[7] = mkv(2, 32'h00800000, 32'h80C00000, 32'd0,        32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[8] = mkv(2, 32'hBF800000, 32'h3F800000, 32'd0,        32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset state.
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sum", out_sum, 32'd0);
        chk("rst_out_count", {16'd0, out_count}, 32'd0);
        chk("rst_flags", {29'd0, exception, overflow, underflow}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Truncation plus a held result with out_ready low for 5 cycles.
        hv = mkv(2, 32'h3F800000, 32'h33800000, 32'd0, 32'h3F800000, 1'b0, 1'b0, 1'b1, 1'b0);
        send_term("hold", hv.t[0], 1'b0);
        send_term("hold", hv.t[1], 1'b1);
        wait_result("hold");
        check_result("hold", hv);
        in_valid = 1'b1; in_data = 32'h40000000; in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d_out_valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("hold%0d_out_sum", c), out_sum, 32'h3F800000);
            chk($sformatf("hold%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
            chk($sformatf("hold%0d_out_count", c), {16'd0, out_count}, 32'd2);
        end
        in_valid = 1'b0; in_last = 1'b0;
        handshake("hold");

        // Reset asserted while the first term is in ALIGN.
        send_term("midrst", 32'h3F800000, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_out_count", {16'd0, out_count}, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_flags", {29'd0, exception, overflow, underflow}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        hv = mkv(1, 32'h40000000, 32'd0, 32'd0, 32'h40000000, 1'b0, 1'b0, 1'b1, 1'b0);
        run_vec("after_rst", hv);

`ifdef FP_ACC_BIAS_EN
        // Bias 3.0 seeds the sum; 3.0 + 1.0 = 4.0.
        bias = 32'h40400000;
        hv = mkv(1, 32'h3F800000, 32'd0, 32'd0, 32'h40800000, 1'b0, 1'b0, 1'b1, 1'b0);
        run_vec("bias", hv);
        bias = 32'd0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp32_mac_accumulator.md
Name: fp32_mac_accumulator

Overview:
- Sequential FP32 accumulator directly downstream of the FP32 multiplier in the neuron datapath.
- Consumes one product per valid/ready handshake and sums the products of a neuron into a running IEEE-754 single-precision value.
- Emits the final sum with sticky status flags when the term flagged last has been added.
- Uses a multi-cycle align/add/normalise FSM, not a pipelined adder.

Parameters:
- CNT_W, 16, width of the term counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- in_valid  in  1  a product term is presented
- in_ready  out  1  accumulator can accept a term
- in_data  in  32  FP32 product term
- in_last  in  1  final term of the current sum
- out_valid  out  1  result is valid
- out_ready  in  1  downstream accepts the result
- out_sum  out  32  FP32 accumulated result
- out_count  out  CNT_W  number of terms summed
- exception  out  1  sticky: any term had exponent 8'hFF
- overflow  out  1  sticky: the sum exceeded the FP32 range
- underflow  out  1  sticky: the sum fell below the normal range

Interface: one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.

Behaviour:
- Reset: all state is cleared asynchronously.
  - state=WAIT; accumulator=+0; count=0.
  - in_ready=0 during reset, then 1 in WAIT.
  - out_valid=0, out_sum=0, out_count=0, all flags=0.
- A reset mid-operation discards the in-flight sum.
- States: WAIT, ALIGN, ADD, NORM, DONE.
- WAIT: in_ready=1.
  - A transfer occurs when in_valid & in_ready.
  - On transfer: latch the term and in_last, increment count (saturating), go to ALIGN.
- ALIGN:
  - A term with exponent 8'hFF sets exception.
  - A term with exponent 0 is flushed to zero.
  - Operands are unpacked to 24-bit magnitudes with the hidden 1.
  - The smaller-exponent mantissa is shifted right by the exponent difference; a shift of 25 or more gives 0.
  - Bits shifted out are dropped (truncation).
- ADD:
  - Same signs: add magnitudes into 25 bits.
  - Different signs: subtract the smaller from the larger; the result takes the sign of the larger.
- NORM:
  - Carry out: shift right 1 and add 1 to the exponent.
  - Otherwise: left-shift by the leading-zero count and subtract it from the exponent.
  - Zero magnitude, including exact cancellation, gives +0.
  - Exponent > 254: write ±inf {s,8'hFF,0} and set overflow.
  - Exponent < 1: write signed zero and set underflow.
  - Write the accumulator. If last was latched go to DONE, else go to WAIT.
- Latency: out_valid rises 3 clock edges after the edge that accepted the last term.
- Throughput: one term per 4 cycles.
- DONE: out_valid=1. out_sum, out_count and flags stay stable until out_valid & out_ready.
  - If exception is set, out_sum=32'd0, matching the multiplier's exception output.
  - On handshake, in the same edge: go to WAIT, set accumulator to its initial value, clear count and flags.
- in_ready=0 in every state except WAIT. There is no bypass of a held result.
- A single term with in_last gives that term, normalised, or flushed if it is subnormal.

Optional Feature:
- Macro: FP_ACC_BIAS_EN.
- Defined:
  - Adds input port bias[31:0].
  - At reset and after every result handshake, the accumulator loads bias instead of +0.
  - bias is sampled on the edge that accepts the first term of a sum.
  - A bias with exponent 8'hFF sets exception.
- Undefined: no bias port; the accumulator starts at +0.

Decomposition:
- Package fp32_pkg:
  - field-width constants SIGN_BIT=31, EXP_W=8, MAN_W=23, EXP_BIAS=127, EXP_MAX=8'hFF;
  - FP_POS_ZERO;
  - state enum for this block;
  - helper functions: unpack to {sign, exp, 24-bit mant}, pack, make_inf(sign).
- One sub-module: fp32_lzc, a combinational 25-bit leading-zero counter used in NORM.

Test Plan:
- 3F800000, 40000000, 3F000000(last) → out_sum=40600000 (3.5), out_count=3, out_valid 3 edges after last accept, flags 0.
- 3FC00000, BFC00000(last) → out_sum=00000000 (+0), no underflow.
- 7F000000, 7F000000(last) → out_sum=7F800000, overflow=1.
- 7F800000, 3F800000(last) → exception=1, out_sum=00000000. Next sum 40000000(last) → 40000000 with flags cleared.
- 3F800000, 33800000(last) → 3F800000 (truncation). Hold out_ready=0 for 5 cycles: out_valid/out_sum stable, in_ready=0 throughout. Assert rst_n=0 mid-ALIGN: outputs clear immediately.
- With FP_ACC_BIAS_EN, bias=40400000, term 3F800000(last) → 40800000 (4.0).
